// File: rtl/fanout_src_serializer.sv
// Launch-stage serialiser for the high-fanout capture register.
// One word in flight, one word held; the serial output is always registered.
module fanout_src_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ser_out,
  output logic             busy,
  output logic             last_bit,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic [BW-1:0]    r_bitcnt;
  logic             r_ser;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_accept;
  logic             w_end;
  logic             w_load;
  logic             w_adv;
  logic             w_to_buf;
  logic             w_buf_pop;
  logic [WIDTH-1:0] w_word;

  // Bit that leaves first, and the word with that bit consumed.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready and status are pure decodes of registered state.
  assign ready_out = ~r_buf_full;
  assign ser_out   = r_ser;
  assign busy      = (r_state == S_SHIFT);
  assign last_bit  = w_end;
  assign frame_cnt = r_frame_cnt;

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = valid_in & ~r_buf_full;
    w_end       = (r_state == S_SHIFT) && (r_bitcnt == LAST_IDX);
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_to_buf    = 1'b0;
    w_buf_pop   = 1'b0;
    w_word      = data_in;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_end) begin
          if (r_buf_full) begin
            w_load    = 1'b1;
            w_word    = r_buf;
            w_buf_pop = 1'b1;
          end else if (w_accept) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_adv    = 1'b1;
          w_to_buf = w_accept;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk1) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Shifter, holding buffer, bit counter and frame counter.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_ser       <= IDLE_LEVEL;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load) begin
        r_ser    <= first_bit(w_word);
        r_shreg  <= drop_bit(w_word);
        r_bitcnt <= '0;
      end else if (w_adv) begin
        r_ser    <= first_bit(r_shreg);
        r_shreg  <= drop_bit(r_shreg);
        r_bitcnt <= r_bitcnt + BW'(1);
      end else begin
        r_ser <= IDLE_LEVEL;
      end
      if (w_to_buf) begin
        r_buf      <= data_in;
        r_buf_full <= 1'b1;
      end else if (w_buf_pop) begin
        r_buf_full <= 1'b0;
      end
      if (w_end) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

endmodule
